seg_decimal_reader: RTL
=======================

# seg_decimal_reader

Reverse path of the summation display chain. The block captures six active-low 7-segment digit buses (seg0 = least significant), decodes each pattern back to a decimal digit, and folds the digits into a binary value with a sequential multiply-by-10 accumulator. It is used to read back or loop-test display outputs and to enter decimal values from segment-style sources.

## Interface
- No parameters. Widths are fixed: six digits and a 20-bit result. 999999 is less than 2^20.
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a conversion; sampled only while idle
- seg0..seg5  input  7 each  active-low segment patterns, bit order {g,f,e,d,c,b,a}; seg0 is the units digit, seg5 is the 10^5 digit
- value  output  20  converted binary result
- done  output  1  one-cycle pulse when a conversion or error completes
- error  output  1  an illegal pattern was found in the last conversion
- busy  output  1  a conversion is in progress

## Operation
- **Legal patterns:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank 1111111 decodes to digit 0 with no error (leading blanks)
  - any other pattern is illegal
- **FSM states:** IDLE, DECODE, ACCUM, FINISH.
- **IDLE**
  - busy=0.
  - If start=1: latch seg0..seg5 into internal registers, clear the accumulator, clear error, go to DECODE.
  - After capture, later changes on the seg inputs have no effect on the conversion in progress.
- **DECODE** (1 cycle)
  - Decode all six latched patterns into 4-bit digits.
  - If any pattern is illegal: error<=1, value<=0, go to FINISH.
  - Otherwise load index=5 and go to ACCUM.
- **ACCUM** (6 cycles, index 5 down to 0)
  - Each cycle: acc <= acc*10 + digit[index].
  - Implement acc*10 as (acc<<3)+(acc<<1) at 20 bits. No overflow is possible.
  - After index 0, value<=acc result and go to FINISH.
- **FINISH** (1 cycle)
  - done=1 for exactly this cycle, then go to IDLE.
- **Held outputs:** value and error hold their last result until the next accepted start. At that start, error clears and value keeps its old content until FINISH.
- **start while busy:** ignored, not queued.
- **rst:** dominates in every state, including mid-conversion. Next state is IDLE and all outputs take their reset values.

## Timing
- **Reset values:** value=0, done=0, error=0, busy=0, state=IDLE, accumulator=0.
- **Reference edge:** edge k is the edge at which start=1 is sampled in IDLE. Segment inputs are captured at edge k.
- **busy:** high from the cycle after edge k through the FINISH cycle inclusive.
- **Normal path:**
  - DECODE occupies cycle k..k+1.
  - ACCUM occupies edges k+2..k+7.
  - value is updated and done asserts in the cycle after edge k+7 (FINISH).
  - Total latency is 8 cycles from the start edge to the done pulse.
- **Error path:** done asserts in the cycle after edge k+1, with error=1 and value=0.
- **Back-to-back conversions:** a new start is accepted no earlier than the first IDLE cycle after FINISH. Minimum spacing is 9 cycles per conversion.
- **Reset during FINISH:** done drops on the same reset edge.

## Test plan
- seg5..seg0 = patterns for 1,2,3,4,5,6, pulse start -> done pulses 8 cycles later; value=123456 (0x1E240); error=0.
- All six inputs blank (1111111) -> value=0, error=0, done after 8 cycles. Patterns for 9 on all digits -> value=999999 (0xF423F).
- seg3=0000001 (illegal), others legal -> done 2 cycles after start, error=1, value=0. A following legal conversion clears error.
- Capture 000042, change all seg inputs to 8 during ACCUM -> value=42. A start pulsed while busy is ignored and exactly one done is produced.
- Assert rst at the third ACCUM cycle -> next cycle busy=0, done=0, value=0. A start after reset with 000007 -> value=7.

Source files
------------

// File: rtl/seg_decimal_reader.sv
// seg_decimal_reader
// Reads six active-low 7-segment digit patterns back into a binary value.
// The patterns are captured on an accepted start and decoded in one cycle.
// The digits are then folded most-significant first with acc*10 + digit.
// An unrecognised pattern ends the conversion early with error set.

module seg_decimal_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  seg0,
    input  logic [6:0]  seg1,
    input  logic [6:0]  seg2,
    input  logic [6:0]  seg3,
    input  logic [6:0]  seg4,
    input  logic [6:0]  seg5,
    output logic [19:0] value,
    output logic        done,
    output logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACCUM  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // Captured patterns, seg0 in the low 7 bits
    logic [41:0] seg_q;
    // Decoded digits, the 10^5 digit in the top nibble so it leaves first
    logic [23:0] digit_q;
    logic [2:0]  index;
    logic [19:0] acc;
    logic [19:0] acc_next;

    logic [23:0] dec_digits;
    logic [5:0]  dec_bad;

    // Maps one pattern to {illegal, digit}; blank reads as a legal zero
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b1000000: res = 5'h00;
            7'b1111001: res = 5'h01;
            7'b0100100: res = 5'h02;
            7'b0110000: res = 5'h03;
            7'b0011001: res = 5'h04;
            7'b0010010: res = 5'h05;
            7'b0000010: res = 5'h06;
            7'b1111000: res = 5'h07;
            7'b0000000: res = 5'h08;
            7'b0010000: res = 5'h09;
            7'b1111111: res = 5'h00;
            default:    res = 5'h10;
        endcase
        return res;
    endfunction

    // Decode all six captured patterns in parallel
    always_comb begin
        logic [4:0] d;
        dec_digits = '0;
        dec_bad    = '0;
        for (int i = 0; i < 6; i++) begin
            d                    = decode_seg(seg_q[i*7 +: 7]);
            dec_digits[i*4 +: 4] = d[3:0];
            dec_bad[i]           = d[4];
        end
    end

    // Multiply by ten as a shift-add and add the digit at the head of the queue
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + {16'd0, digit_q[23:20]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (|dec_bad) begin
                    state_next = FINISH;
                end else begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (index == 3'd0) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture, decode, accumulate and hold the result between conversions
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= '0;
            digit_q <= '0;
            index   <= '0;
            acc     <= '0;
            value   <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        seg_q <= {seg5, seg4, seg3, seg2, seg1, seg0};
                        acc   <= '0;
                        error <= 1'b0;
                    end
                end
                DECODE: begin
                    if (|dec_bad) begin
                        error <= 1'b1;
                        value <= '0;
                    end else begin
                        digit_q <= {dec_digits[23:20], dec_digits[19:16], dec_digits[15:12],
                                    dec_digits[11:8], dec_digits[7:4], dec_digits[3:0]};
                        index   <= 3'd5;
                    end
                end
                ACCUM: begin
                    acc     <= acc_next;
                    digit_q <= {digit_q[19:0], 4'd0};
                    index   <= index - 3'd1;
                    if (index == 3'd0) begin
                        value <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
